// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and width defaults for the sequencer, ROM and offset LUT
package core_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int OFF_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        MEM   = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/control bundle between the core and the pc_sequencer
interface pc_sequencer_if
    import core_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int CNT_W = 16
);

    logic             start_i;
    logic [PC_W-1:0]  start_pc_i;
    logic             done_i;
    logic             branchf_i;
    logic             branchb_i;
    logic [OFF_W-1:0] offset_i;
    logic             memread_i;
    logic             memwrite_i;
    logic [PC_W-1:0]  pc_o;
    logic             fetch_o;
    logic             commit_o;
    logic             busy_o;
    logic             halted_o;
    logic [CNT_W-1:0] instr_count_o;

    modport master (
        output start_i, start_pc_i, done_i, branchf_i, branchb_i,
               offset_i, memread_i, memwrite_i,
        input  pc_o, fetch_o, commit_o, busy_o, halted_o, instr_count_o
    );

    modport slave (
        input  start_i, start_pc_i, done_i, branchf_i, branchb_i,
               offset_i, memread_i, memwrite_i,
        output pc_o, fetch_o, commit_o, busy_o, halted_o, instr_count_o
    );

endinterface

// File: rtl/pc_sequencer_pc_next.sv
// rtl/pc_sequencer_pc_next.sv - combinational next-PC: increment, forward or backward branch
module pc_next
    import core_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic [OFF_W-1:0] i_offset,
    input  logic             i_branchf,
    input  logic             i_branchb,
    output logic [PC_W-1:0]  o_pc_next
);

    logic [PC_W-1:0] w_off;

    // Offset is an unsigned magnitude; direction comes from branchf/branchb.
    assign w_off = PC_W'(i_offset);

    always_comb begin
        o_pc_next = i_pc + 1'b1;
        if (i_branchf) begin
            o_pc_next = i_pc + w_off;
        end else if (i_branchb) begin
            o_pc_next = i_pc - w_off;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/exec/mem sequencer owning the program counter
module pc_sequencer
    import core_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int OFF_W   = OFF_W_DEF,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic           clk_i,
    input  logic           reset_i,
    pc_sequencer_if.slave  bus
);

    localparam int               WAIT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
    localparam logic             HAS_MEM   = (MEM_LAT > 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_pc_pend;
    logic [WAIT_W-1:0] r_wait;
    logic              r_halted;
    logic [CNT_W-1:0]  r_count;

    logic [PC_W-1:0]   w_pc_next;
    logic [CNT_W-1:0]  w_count_inc;
    logic              w_mem_op;
    logic              w_commit;

    pc_next #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .i_pc      (r_pc),
        .i_offset  (bus.offset_i),
        .i_branchf (bus.branchf_i),
        .i_branchb (bus.branchb_i),
        .o_pc_next (w_pc_next)
    );

    assign w_mem_op    = HAS_MEM && (bus.memread_i || bus.memwrite_i);
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

    // Commit gates every architectural write, so it must drop the instant
    // reset forces IDLE; hence decoded from state rather than registered.
    always_comb begin
        w_commit = 1'b0;
        case (r_state)
            EXEC:    w_commit = !bus.done_i && !w_mem_op;
            MEM:     w_commit = (r_wait == '0);
            default: w_commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_pc_pend <= '0;
            r_wait    <= '0;
            r_halted  <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_pc     <= bus.start_pc_i;
                        r_halted <= 1'b0;
                        r_count  <= '0;
                        r_state  <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (bus.done_i) begin
                        r_halted <= 1'b1;
                        r_count  <= w_count_inc;
                        r_state  <= IDLE;
                    end else if (w_mem_op) begin
                        // Branch decision is frozen here; decoder may move on during MEM.
                        r_wait    <= WAIT_LOAD;
                        r_pc_pend <= w_pc_next;
                        r_state   <= MEM;
                    end else begin
                        r_pc    <= w_pc_next;
                        r_count <= w_count_inc;
                        r_state <= FETCH;
                    end
                end
                MEM: begin
                    if (r_wait != '0) begin
                        r_wait <= r_wait - 1'b1;
                    end else begin
                        r_pc    <= r_pc_pend;
                        r_count <= w_count_inc;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.fetch_o       = (r_state == FETCH);
    assign bus.commit_o      = w_commit;
    assign bus.busy_o        = (r_state != IDLE);
    assign bus.halted_o      = r_halted;
    assign bus.instr_count_o = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    import core_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk_i = ~clk_i;

    pc_sequencer_if #(.PC_W(10), .OFF_W(8), .CNT_W(16)) sif ();
    pc_sequencer_if #(.PC_W(10), .OFF_W(8), .CNT_W(2))  tif ();

    pc_sequencer #(.PC_W(10), .OFF_W(8), .MEM_LAT(1), .CNT_W(16)) u_dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (sif.slave)
    );

    pc_sequencer #(.PC_W(10), .OFF_W(8), .MEM_LAT(3), .CNT_W(2)) u_dut_lat3 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (tif.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_dec();
        sif.done_i = 0; sif.branchf_i = 0; sif.branchb_i = 0;
        sif.offset_i = 8'h00; sif.memread_i = 0; sif.memwrite_i = 0;
    endtask

    task automatic start_at(input logic [9:0] pc);
        sif.start_i = 1; sif.start_pc_i = pc;
        tick();
        sif.start_i = 0;
        check("start_pc", sif.pc_o, pc);
        check("start_cnt", sif.instr_count_o, 0);
        check("start_halted", sif.halted_o, 0);
    endtask

    // Entered in FETCH; returns in the next FETCH.
    task automatic exec_instr(input string tag, input logic bf, input logic bb,
                              input logic [7:0] off, input logic rd, input logic wr,
                              input logic [9:0] exp_pc);
        check({tag, "_fetch"}, sif.fetch_o, 1);
        check({tag, "_commit_f"}, sif.commit_o, 0);
        tick();
        sif.branchf_i = bf; sif.branchb_i = bb; sif.offset_i = off;
        sif.memread_i = rd; sif.memwrite_i = wr;
        #1;
        check({tag, "_fetch_e"}, sif.fetch_o, 0);
        check({tag, "_commit_e"}, sif.commit_o, !(rd | wr));
        if (rd | wr) begin
            tick();
            sif.branchf_i = ~bf; sif.branchb_i = ~bb; sif.offset_i = 8'hA5;
            sif.memread_i = 0; sif.memwrite_i = 0; sif.done_i = 1;
            #1;
            check({tag, "_commit_m"}, sif.commit_o, 1);
        end
        tick();
        clear_dec();
        check({tag, "_pc"}, sif.pc_o, exp_pc);
    endtask

    task automatic halt_instr(input string tag, input logic [9:0] exp_pc, input logic [15:0] exp_cnt);
        check({tag, "_fetch"}, sif.fetch_o, 1);
        tick();
        sif.done_i = 1;
        #1;
        check({tag, "_commit"}, sif.commit_o, 0);
        tick();
        sif.done_i = 0;
        check({tag, "_busy"}, sif.busy_o, 0);
        check({tag, "_halted"}, sif.halted_o, 1);
        check({tag, "_pc"}, sif.pc_o, exp_pc);
        check({tag, "_cnt"}, sif.instr_count_o, exp_cnt);
    endtask

    initial begin
        reset_i = 1;
        sif.start_i = 0; sif.start_pc_i = '0; clear_dec();
        tif.start_i = 0; tif.start_pc_i = '0; tif.done_i = 0; tif.branchf_i = 0;
        tif.branchb_i = 0; tif.offset_i = '0; tif.memread_i = 0; tif.memwrite_i = 0;
        tick();
        tick();
        check("rst_pc", sif.pc_o, 0);
        check("rst_fetch", sif.fetch_o, 0);
        check("rst_commit", sif.commit_o, 0);
        check("rst_busy", sif.busy_o, 0);
        check("rst_halted", sif.halted_o, 0);
        check("rst_cnt", sif.instr_count_o, 0);
        reset_i = 0;
        tick();
        check("idle_busy", sif.busy_o, 0);

        // Straight-line ALU code
        start_at(10'h010);
        check("run_busy", sif.busy_o, 1);
        exec_instr("alu0", 0, 0, 8'd0, 0, 0, 10'h011);
        exec_instr("alu1", 0, 0, 8'd0, 0, 0, 10'h012);
        exec_instr("alu2", 0, 0, 8'd0, 0, 0, 10'h013);
        check("alu_cnt3", sif.instr_count_o, 3);

        // start while busy must not disturb the PC
        sif.start_i = 1; sif.start_pc_i = 10'h200;
        exec_instr("busy_start", 0, 0, 8'd0, 0, 0, 10'h014);
        sif.start_i = 0;
        halt_instr("halt1", 10'h014, 16'd5);
        tick();
        check("idle_pc_hold", sif.pc_o, 10'h014);
        check("idle_halt_hold", sif.halted_o, 1);

        // Branches
        start_at(10'h020);
        exec_instr("bf5", 1, 0, 8'd5, 0, 0, 10'h025);
        exec_instr("bb5a", 0, 1, 8'd5, 0, 0, 10'h020);
        exec_instr("bb5b", 0, 1, 8'd5, 0, 0, 10'h01B);
        exec_instr("bf5b", 1, 0, 8'd5, 0, 0, 10'h020);
        exec_instr("both5", 1, 1, 8'd5, 0, 0, 10'h025);

        // Memory ops, MEM_LAT=1; store carries a branch decided in EXEC
        exec_instr("load", 0, 0, 8'd0, 1, 0, 10'h026);
        exec_instr("st_bf3", 1, 0, 8'd3, 0, 1, 10'h029);
        exec_instr("bf7", 1, 0, 8'd7, 0, 0, 10'h030);
        check("mid_cnt", sif.instr_count_o, 8);

        // Halt with start already high: start is only seen one cycle after IDLE
        sif.start_i = 1; sif.start_pc_i = 10'h3FF;
        halt_instr("halt30", 10'h030, 16'd9);
        tick();
        sif.start_i = 0;
        check("restart_pc", sif.pc_o, 10'h3FF);
        check("restart_halted", sif.halted_o, 0);
        check("restart_cnt", sif.instr_count_o, 0);
        check("restart_fetch", sif.fetch_o, 1);

        // Wrap-around
        exec_instr("wrap_inc", 0, 0, 8'd0, 0, 0, 10'h000);
        exec_instr("inc1", 0, 0, 8'd0, 0, 0, 10'h001);
        exec_instr("inc2", 0, 0, 8'd0, 0, 0, 10'h002);
        exec_instr("wrap_bb4", 0, 1, 8'd4, 0, 0, 10'h3FE);
        check("wrap_cnt", sif.instr_count_o, 4);

        // Async reset during MEM
        tick();
        sif.memread_i = 1;
        tick();
        sif.memread_i = 0;
        #1;
        check("mem_commit_pre", sif.commit_o, 1);
        #2;
        reset_i = 1;
        #1;
        check("arst_commit", sif.commit_o, 0);
        check("arst_busy", sif.busy_o, 0);
        check("arst_pc", sif.pc_o, 0);
        check("arst_cnt", sif.instr_count_o, 0);
        check("arst_fetch", sif.fetch_o, 0);
        tick();
        check("arst_pc_edge", sif.pc_o, 0);
        reset_i = 0;
        tick();
        check("arst_idle", sif.busy_o, 0);

        // MEM_LAT=3 instance: 5-cycle store, then 2-bit counter saturation
        tif.start_i = 1; tif.start_pc_i = 10'h100;
        tick();
        tif.start_i = 0;
        check("l3_fetch", tif.fetch_o, 1);
        check("l3_pc0", tif.pc_o, 10'h100);
        tick();
        tif.memwrite_i = 1;
        #1;
        check("l3_commit_e", tif.commit_o, 0);
        tick();
        tif.memwrite_i = 0;
        #1;
        check("l3_commit_m2", tif.commit_o, 0);
        tick();
        check("l3_commit_m1", tif.commit_o, 0);
        tick();
        check("l3_commit_m0", tif.commit_o, 1);
        tick();
        check("l3_pc1", tif.pc_o, 10'h101);
        check("l3_cnt1", tif.instr_count_o, 1);
        check("l3_fetch1", tif.fetch_o, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("l3_alu_commit", tif.commit_o, 1);
            tick();
            check("l3_sat_cnt", tif.instr_count_o, (i > 3) ? 3 : i);
            check("l3_alu_pc", tif.pc_o, 10'h100 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
